// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the RISC2 iterative multiply/divide unit.
// Holds the operation codes, the controller state codes and the register width.
package riscv_muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Request fields captured at acceptance and held until write-back.
    typedef struct packed {
        logic [1:0] op;
        logic [4:0] rd;
    } md_req_t;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider with a single
// register-file write-back port; multiply and divide share one shift register.
module muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd,
    output logic             busy,
    output logic             done,
    output logic [4:0]       wa3,
    output logic [WIDTH-1:0] wd3,
    output logic             we3
);

    // Handshake: start is taken only while busy=0 (state IDLE); once taken,
    // busy stays high until the cycle after the one-cycle done/we3 pulse, and
    // start is ignored for that whole window (no queueing).

    logic [1:0]         state;
    logic [5:0]         count;
    md_req_t            req_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [WIDTH:0]     rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   result;

    // Multiply: acc = {partial high word, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    // A zero divisor always passes the trial subtract, so the quotient fills
    // with ones and the remainder ends up equal to the dividend.
    always_comb begin
        div_shift = (WIDTH+1)'({rem, acc[WIDTH-1]});
        div_trial = div_shift - {1'b0, b_q};
        div_ok    = ~div_trial[WIDTH];
        rem_next  = div_ok ? div_trial : div_shift;
        div_next  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ok};
    end

    always_comb begin
        result = '0;
        case (req_q.op)
            MD_MUL:   result = acc[WIDTH-1:0];
            MD_MULHU: result = acc[2*WIDTH-1:WIDTH];
            MD_DIVU:  result = acc[WIDTH-1:0];
            MD_REMU:  result = rem[WIDTH-1:0];
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            req_q <= '0;
            b_q   <= '0;
            acc   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req_q <= '{op: op, rd: rd};
                        b_q   <= b;
                        acc   <= {{WIDTH{1'b0}}, a};
                        rem   <= '0;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (md_is_div(req_q.op)) begin
                        acc <= div_next;
                        rem <= rem_next;
                    end else begin
                        acc <= mul_next;
                    end
                    count <= count + 6'd1;
                    if (count == 6'(WIDTH-1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only; write-back fields read zero
    // outside DONE so the register-file port is quiet between operations.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        we3  = done && (req_q.rd != 5'd0);
        wa3  = done ? req_q.rd : 5'd0;
        wd3  = done ? result : '0;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: drivers push expected write-backs into a
// queue and an independent monitor checks every done/we3 pulse against it.
module tb_muldiv_unit;
    import riscv_muldiv_pkg::*;

    localparam int W = 32;
    localparam int EW = 1 + 5 + W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [4:0]    rd = '0;
    logic          busy;
    logic          done;
    logic [4:0]    wa3;
    logic [W-1:0]  wd3;
    logic          we3;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd(rd),
        .busy(busy), .done(done), .wa3(wa3), .wd3(wd3), .we3(we3)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (done || we3)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_writeback: done=%0b we3=%0b wa3=%0d wd3=0x%0h", done, we3, wa3, wd3);
            end else begin
                logic [EW-1:0] e;
                int            lat;
                e   = exp_q.pop_front();
                lat = lat_q.pop_front();
                check("writeback {we3,wa3,wd3}", 64'({we3, wa3, wd3}), 64'(e));
                check("done_with_we3", 64'(done), 64'd1);
                check("done_cycle", 64'(cycle), 64'(lat));
            end
        end
    end

    // driver: issue one op, optionally poke start mid-run, count busy cycles
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [4:0] r, input logic [W-1:0] exp_wd, input int poke_at);
        int busy_n;
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; rd = r;
        @(posedge clk);
        #1;
        exp_q.push_back({(r != 5'd0), r, exp_wd});
        lat_q.push_back(cycle + 32);
        busy_n = 0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (n == poke_at) begin
                start = 1'b1; op = MD_DIVU; a = 32'd1; b = 32'd1; rd = 5'd11;
            end else begin
                start = 1'b0; a = $urandom(); b = $urandom(); rd = 5'($urandom_range(0, 31));
            end
            if (!busy) break;
            busy_n++;
            n++;
        end
        start = 1'b0;
        check("busy_cycles", 64'(busy_n), 64'd33);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_we3", 64'(we3), 64'd0);
        check("reset_wa3", 64'(wa3), 64'd0);
        check("reset_wd3", 64'(wd3), 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        issue(MD_MUL,   32'd7,          32'd6,          5'd5,  32'd42,         -1);
        issue(MD_MULHU, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd3,  32'hFFFFFFFE,   -1);
        issue(MD_MUL,   32'hFFFFFFFF,   32'hFFFFFFFF,   5'd4,  32'h00000001,   -1);
        issue(MD_DIVU,  32'd100,        32'd7,          5'd6,  32'd14,         -1);
        issue(MD_REMU,  32'd100,        32'd7,          5'd7,  32'd2,          -1);
        issue(MD_DIVU,  32'h1234,       32'd0,          5'd8,  32'hFFFFFFFF,   -1);
        issue(MD_REMU,  32'h1234,       32'd0,          5'd9,  32'h1234,       -1);
        issue(MD_MUL,   32'd3,          32'd5,          5'd0,  32'd15,         -1);
        issue(MD_MUL,   32'd11,         32'd13,         5'd10, 32'd143,        5);
        idle_cycles(5);

        // reset mid-run once count has reached 10
        @(negedge clk);
        start = 1'b1; op = MD_MUL; a = 32'd2; b = 32'd2; rd = 5'd12;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        check("midrun_reset_we3", 64'(we3), 64'd0);
        rst = 1'b0;
        idle_cycles(40);

        issue(MD_DIVU,  32'hFFFFFFFF,   32'h10,         5'd13, 32'h0FFFFFFF,   -1);
        issue(MD_REMU,  32'hFFFFFFFF,   32'h10,         5'd14, 32'hF,          -1);
        issue(MD_DIVU,  32'hFFFFFFFF,   32'h80000001,   5'd15, 32'd1,          -1);
        issue(MD_REMU,  32'hFFFFFFFF,   32'h80000001,   5'd16, 32'h7FFFFFFE,   -1);
        issue(MD_MULHU, 32'h80000000,   32'd6,          5'd17, 32'd3,          -1);
        idle_cycles(5);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
